// File: rtl/ps2_teclado_fifo.sv
// ps2_teclado_fifo -- PS/2 keyboard receiver with E0/F0 decoding and key FIFO.
//  Conditions the asynchronous PS/2 pins (2-FF sync + hold filter on the clock),
//  frames 11-bit PS/2 words, folds E0/F0 prefixes into flags and queues the
//  decoded keys in a first-word fall-through FIFO for the PicoBlaze side.
// Ports:
//  CLK, RST              system clock, synchronous active-high reset
//  PS2D, PS2C            asynchronous PS/2 data/clock pins
//  interrupcion_paro     pop strobe (one entry per high cycle)
//  TECLA/_EXT/_BREAK     FIFO head entry, zero when empty
//  interrupcion          FIFO non-empty
//  FIFO_COUNT            queued entries
//  ERR_PARITY/TIMEOUT    single-cycle error pulses
//  OVERFLOW              sticky, cleared only by RST
module ps2_teclado_fifo #(
  parameter int FILTER_LEN   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int BREAK_FILTER = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PS2D,
  input  logic                          PS2C,
  input  logic                          interrupcion_paro,
  output logic [7:0]                    TECLA,
  output logic                          TECLA_EXT,
  output logic                          TECLA_BREAK,
  output logic                          interrupcion,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          ERR_PARITY,
  output logic                          ERR_TIMEOUT,
  output logic                          OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // ---------------- input conditioning ----------------
  logic [1:0]    ps2c_s_q, ps2d_s_q;
  logic          fclk_q, fclk_prev_q;
  logic [FW-1:0] fcnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps2c_s_q    <= 2'b11;
      ps2d_s_q    <= 2'b11;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      ps2c_s_q    <= {ps2c_s_q[0], PS2C};
      ps2d_s_q    <= {ps2d_s_q[0], PS2D};
      fclk_prev_q <= fclk_q;
      // fclk follows only after FILTER_LEN consecutive cycles of disagreement
      if (ps2c_s_q[1] != fclk_q) begin
        if (fcnt_q == FLT_MAX) begin
          fclk_q <= ps2c_s_q[1];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  logic fall, sd;
  assign fall = fclk_prev_q & ~fclk_q;
  assign sd   = ps2d_s_q[1];

  // ---------------- frame FSM ----------------
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;    // running XOR of data+parity bits
  logic [TW-1:0] to_q, to_d;
  logic          fv_q, fv_d;      // valid byte available to the decoder
  logic          perr_d, terr_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    to_d     = to_q;
    fv_d     = 1'b0;
    perr_d   = 1'b0;
    terr_d   = 1'b0;
    if (state_q == S_IDLE) begin
      to_d = '0;
      if (fall && !sd) begin
        state_d  = S_DATA;
        bitcnt_d = 3'd0;
        par_d    = 1'b0;
      end
    end else if (fall) begin
      to_d = '0;
      case (state_q)
        S_DATA: begin
          sh_d     = {sd, sh_q[7:1]};
          par_d    = par_q ^ sd;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = par_q ^ sd;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (sd && par_q) fv_d = 1'b1;
          else             perr_d = 1'b1;
        end
      endcase
    end else if (to_q == TO_MAX) begin
      state_d = S_IDLE;
      terr_d  = 1'b1;
      to_d    = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      fv_q        <= 1'b0;
      ERR_PARITY  <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      to_q        <= to_d;
      fv_q        <= fv_d;
      ERR_PARITY  <= perr_d;
      ERR_TIMEOUT <= terr_d;
    end
  end

  // ---------------- prefix decoder ----------------
  logic ext_q, ext_d, brk_q, brk_d, push;

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (fv_q) begin
      if (sh_q == 8'hE0)      ext_d = 1'b1;
      else if (sh_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = !((BREAK_FILTER != 0) && brk_q);
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // ---------------- key FIFO ----------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push, full;

  assign full    = (cnt_q == DEPTH_C);
  assign do_pop  = interrupcion_paro && (cnt_q != '0);
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= {ext_q, brk_q, sh_q};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (push && !do_push) OVERFLOW <= 1'b1;
    end
  end

  logic [9:0] head;
  assign head         = mem_q[rd_q];
  assign interrupcion = (cnt_q != '0);
  assign TECLA        = interrupcion ? head[7:0] : 8'h00;
  assign TECLA_BREAK  = interrupcion ? head[8]   : 1'b0;
  assign TECLA_EXT    = interrupcion ? head[9]   : 1'b0;
  assign FIFO_COUNT   = cnt_q;
endmodule
